dmem_ctrl: RTL and testbench

Data-memory controller sitting between the pipeline's memory stage and the external data bus. It accepts one load/store request at a time from the execute/memory boundary and converts it into a single word-aligned bus transaction with byte strobes. It holds the pipeline with `stall` until the transaction completes, then returns size-extracted, sign- or zero-extended load data.

---
 rtl/br32_mem_pkg.sv | 51 +++++
 rtl/load_align.sv | 31 +++
 rtl/dmem_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_dmem_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/br32_mem_pkg.sv
// Shared types and helpers for the data-memory path.
//   mem_sz_t     : access size encoding (byte/half/word)
//   dmem_state_t : dmem_ctrl FSM states
//   decode_sz    : raw 2-bit size to mem_sz_t (3 folds onto word)
//   wstrb_of     : byte-enable pattern for a size/lane pair
//   byte_lane / half_lane : raw lane select from a bus word
//   misaligned   : alignment fault predicate (used by the trap build)
package br32_mem_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } mem_sz_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_RDATA,
    ST_DONE
  } dmem_state_t;

  function automatic mem_sz_t decode_sz(input logic [1:0] sz);
    case (sz)
      2'd0:    return SZ_B;
      2'd1:    return SZ_H;
      default: return SZ_W;
    endcase
  endfunction

  function automatic logic [3:0] wstrb_of(input mem_sz_t sz, input logic [1:0] lane);
    case (sz)
      SZ_B:    return 4'b0001 << lane;
      SZ_H:    return 4'b0011 << {lane[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [7:0] byte_lane(input logic [31:0] w, input logic [1:0] lane);
    return w[{lane, 3'b000} +: 8];
  endfunction

  function automatic logic [15:0] half_lane(input logic [31:0] w, input logic sel);
    return sel ? w[31:16] : w[15:0];
  endfunction

  function automatic logic misaligned(input mem_sz_t sz, input logic [1:0] lane);
    return ((sz == SZ_H) && lane[0]) || ((sz == SZ_W) && (lane != 2'b00));
  endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load-data alignment: selects the addressed byte/half lane
// from a bus word and sign- or zero-extends it to 32 bits.
//   sz   : access size (0 byte, 1 half, 2/3 word)
//   sx   : 1 = sign-extend, 0 = zero-extend
//   lane : byte address low bits (half uses lane[1] only)
//   word : raw 32-bit bus word
//   data : aligned, extended result
module load_align
  import br32_mem_pkg::*;
(
  input  logic [1:0]  sz,
  input  logic        sx,
  input  logic [1:0]  lane,
  input  logic [31:0] word,
  output logic [31:0] data
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = byte_lane(word, lane);
    h = half_lane(word, lane[1]);
    case (decode_sz(sz))
      SZ_B:    data = {{24{sx & b[7]}}, b};
      SZ_H:    data = {{16{sx & h[15]}}, h};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: turns one pipeline load/store into a single
// word-aligned bus transaction with byte strobes, stalls the pipeline until
// it completes, and returns aligned/extended load data.
//   Pipeline side : clk, rstn, exn, req_valid/we/addr/wdata/sz/sx,
//                   stall, rdata, rdata_valid, misalign
//   Bus side      : bus_valid/ready/we/addr/wstrb/wdata, bus_rvalid/rdata
// Build option: DMEM_MISALIGN_TRAP_EN -- misaligned half/word accesses skip
// the bus and raise a one-cycle misalign pulse. Without it the low address
// bits a size cannot use are ignored and misalign is tied low.
module dmem_ctrl
  import br32_mem_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        exn,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_sz,
  input  logic        req_sx,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        misalign,
  output logic        bus_valid,
  input  logic        bus_ready,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  dmem_state_t state_q, state_d;
  logic        killed_q, killed_d;
  mem_sz_t     sz_q, sz_d;
  logic        sx_q, sx_d;
  logic [1:0]  lane_q, lane_d;
  logic        bus_valid_q, bus_valid_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [3:0]  bus_wstrb_q, bus_wstrb_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] load_data;
  mem_sz_t     req_size;

`ifdef DMEM_MISALIGN_TRAP_EN
  logic        misal_q, misal_d;
`endif

  load_align u_load_align (
    .sz   (sz_q),
    .sx   (sx_q),
    .lane (lane_q),
    .word (bus_rdata),
    .data (load_data)
  );

  assign req_size = decode_sz(req_sz);

  always_comb begin
    state_d     = state_q;
    killed_d    = killed_q;
    sz_d        = sz_q;
    sx_d        = sx_q;
    lane_d      = lane_q;
    bus_valid_d = bus_valid_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wstrb_d = bus_wstrb_q;
    bus_wdata_d = bus_wdata_q;
    rdata_d     = rdata_q;
`ifdef DMEM_MISALIGN_TRAP_EN
    misal_d     = misal_q;
`endif
    case (state_q)
      ST_IDLE: begin
        killed_d = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
        misal_d  = 1'b0;
`endif
        if (req_valid && !exn) begin
          sz_d        = req_size;
          sx_d        = req_sx;
          lane_d      = req_addr[1:0];
          bus_we_d    = req_we;
          bus_addr_d  = {req_addr[31:2], 2'b00};
          bus_wdata_d = req_wdata;
          bus_wstrb_d = req_we ? wstrb_of(req_size, req_addr[1:0]) : '0;
          state_d     = ST_ADDR;
          bus_valid_d = 1'b1;
`ifdef DMEM_MISALIGN_TRAP_EN
          if (misaligned(req_size, req_addr[1:0])) begin
            state_d     = ST_DONE;
            bus_valid_d = 1'b0;
            misal_d     = 1'b1;
          end
`endif
        end
      end
      ST_ADDR: begin
        if (exn) killed_d = 1'b1;
        // The request is never withdrawn once raised; a flush only marks it.
        if (bus_ready) begin
          bus_valid_d = 1'b0;
          state_d     = bus_we_q ? ST_DONE : ST_RDATA;
        end
      end
      ST_RDATA: begin
        if (exn) killed_d = 1'b1;
        if (bus_rvalid) begin
          rdata_d = load_data;
          state_d = ST_DONE;
        end
      end
      default: begin
        // Clearing here makes killed low on entry to IDLE.
        killed_d = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      killed_q    <= 1'b0;
      sz_q        <= SZ_B;
      sx_q        <= 1'b0;
      lane_q      <= '0;
      bus_valid_q <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wstrb_q <= '0;
      bus_wdata_q <= '0;
      rdata_q     <= '0;
`ifdef DMEM_MISALIGN_TRAP_EN
      misal_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      killed_q    <= killed_d;
      sz_q        <= sz_d;
      sx_q        <= sx_d;
      lane_q      <= lane_d;
      bus_valid_q <= bus_valid_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wstrb_q <= bus_wstrb_d;
      bus_wdata_q <= bus_wdata_d;
      rdata_q     <= rdata_d;
`ifdef DMEM_MISALIGN_TRAP_EN
      misal_q     <= misal_d;
`endif
    end
  end

  // A flush arriving in DONE itself also suppresses the completion pulse.
  logic done_ok;
  assign done_ok = (state_q == ST_DONE) && !killed_q && !exn;

  assign stall = ((state_q == ST_IDLE) && req_valid && !exn) ||
                 (state_q == ST_ADDR) || (state_q == ST_RDATA);

`ifdef DMEM_MISALIGN_TRAP_EN
  assign rdata_valid = done_ok && !misal_q;
  assign misalign    = done_ok && misal_q;
`else
  assign rdata_valid = done_ok;
  assign misalign    = 1'b0;
`endif

  assign rdata     = rdata_q;
  assign bus_valid = bus_valid_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wstrb = bus_wstrb_q;
  assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
module tb_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic        exn;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_sz;
  logic        req_sx;
  logic        stall;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        misalign;
  logic        bus_valid;
  logic        bus_ready;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  dmem_ctrl dut (
    .clk         (clk),
    .rstn        (rstn),
    .exn         (exn),
    .req_valid   (req_valid),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_sz      (req_sz),
    .req_sx      (req_sx),
    .stall       (stall),
    .rdata       (rdata),
    .rdata_valid (rdata_valid),
    .misalign    (misalign),
    .bus_valid   (bus_valid),
    .bus_ready   (bus_ready),
    .bus_we      (bus_we),
    .bus_addr    (bus_addr),
    .bus_wstrb   (bus_wstrb),
    .bus_wdata   (bus_wdata),
    .bus_rvalid  (bus_rvalid),
    .bus_rdata   (bus_rdata)
  );

  // Reference: what a load of this size/address returns from a bus word.
  function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [31:0] a,
                                           input logic [1:0] sz, input logic sx);
    logic [31:0] v;
    int unsigned sh;
    if (sz == 2'd0) begin
      sh = 8 * int'(a[1:0]);
      v  = (word >> sh) & 32'hFF;
      if (sx && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      sh = 16 * int'(a[1]);
      v  = (word >> sh) & 32'hFFFF;
      if (sx && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end else begin
      v = word;
    end
    return v;
  endfunction

  // Reference: byte enables a store of this size/address must drive.
  function automatic logic [3:0] ref_strb(input logic [31:0] a, input logic [1:0] sz);
    int unsigned n;
    if (sz == 2'd0)      n = 1 << int'(a[1:0]);
    else if (sz == 2'd1) n = 3 << (2 * int'(a[1]));
    else                 n = 15;
    return 4'(n);
  endfunction

  function automatic bit ref_misaligned(input logic [31:0] a, input logic [1:0] sz);
`ifdef DMEM_MISALIGN_TRAP_EN
    return (sz == 2'd1 && a[0]) || (sz >= 2'd2 && a[1:0] != 2'b00);
`else
    return 1'b0;
`endif
  endfunction

  // One complete access. exn_cyc: -1 none, 0 random non-IDLE cycle, >=1 exact
  // cycle index (cycle 0 is the accepting IDLE cycle). Leaves req_valid high
  // through DONE so the next call can follow back-to-back.
  task automatic run_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [1:0] sz, input logic sx, input logic [31:0] rdword,
                            input int rdy_dly, input int rv_dly, input int exn_cyc_in,
                            input bit junk_rv, input string tag);
    bit          mis, killed, done;
    int          exp_stall, exp_vcnt, exn_cyc;
    int          cyc, stalls, vcnt, hs_cyc, rv_pulses, mis_pulses;
    logic [31:0] exp_rd;
    mis       = ref_misaligned(addr, sz);
    exp_stall = mis ? 1 : (we ? rdy_dly + 2 : rdy_dly + rv_dly + 3);
    exp_vcnt  = mis ? 0 : rdy_dly + 1;
    exn_cyc   = exn_cyc_in;
    if (exn_cyc == 0)
      exn_cyc = (exp_stall > 1) ? int'($urandom_range(exp_stall - 1, 1)) : -1;
    killed    = (exn_cyc >= 1);
    exp_rd    = ref_load(rdword, addr, sz, sx);
    cyc = 0; stalls = 0; vcnt = 0; hs_cyc = -1; rv_pulses = 0; mis_pulses = 0; done = 0;
    while (!done && cyc < 64) begin
      @(negedge clk);
      req_valid  = 1'b1;
      req_we     = we;
      req_addr   = addr;
      req_wdata  = wdata;
      req_sz     = sz;
      req_sx     = sx;
      exn        = (cyc == exn_cyc);
      bus_ready  = bus_valid && (vcnt == rdy_dly);
      bus_rvalid = 1'b0;
      bus_rdata  = $urandom;
      if (hs_cyc >= 0 && !we && cyc == hs_cyc + 1 + rv_dly) begin
        bus_rvalid = 1'b1;
        bus_rdata  = rdword;
      end else if (junk_rv && bus_valid) begin
        bus_rvalid = 1'b1;
      end
      #1;
      if (bus_valid) begin
        vcnt++;
        if (bus_ready) begin
          hs_cyc = cyc;
          n_checks++;
          if (bus_addr !== {addr[31:2], 2'b00} || bus_we !== we ||
              bus_wstrb !== (we ? ref_strb(addr, sz) : 4'b0000) ||
              (we && bus_wdata !== wdata)) begin
            n_errors++;
            $display("FAIL %s bus_req: addr=%h we=%b strb=%b wdata=%h, required addr=%h we=%b strb=%b wdata=%h",
                     tag, bus_addr, bus_we, bus_wstrb, bus_wdata, {addr[31:2], 2'b00}, we,
                     (we ? ref_strb(addr, sz) : 4'b0000), wdata);
          end
        end
      end
      if (rdata_valid) rv_pulses++;
      if (misalign) mis_pulses++;
      if (stall) stalls++;
      else done = 1;
      if (done && rdata_valid && !we) begin
        n_checks++;
        if (rdata !== exp_rd) begin
          n_errors++;
          $display("FAIL %s rdata: got %h, required %h", tag, rdata, exp_rd);
        end
      end
      cyc++;
    end
    exn = 1'b0;
    n_checks++;
    if (!done) begin
      n_errors++;
      $display("FAIL %s timeout: no completion after %0d cycles", tag, cyc);
      return;
    end
    if (stalls != exp_stall) begin
      n_errors++;
      $display("FAIL %s stall_cycles: got %0d, required %0d", tag, stalls, exp_stall);
    end
    n_checks++;
    if (vcnt != exp_vcnt) begin
      n_errors++;
      $display("FAIL %s bus_valid_cycles: got %0d, required %0d", tag, vcnt, exp_vcnt);
    end
    n_checks++;
    if (rv_pulses != ((killed || mis) ? 0 : 1)) begin
      n_errors++;
      $display("FAIL %s rdata_valid_pulses: got %0d, required %0d", tag, rv_pulses,
               ((killed || mis) ? 0 : 1));
    end
    n_checks++;
    if (mis_pulses != ((mis && !killed) ? 1 : 0)) begin
      n_errors++;
      $display("FAIL %s misalign_pulses: got %0d, required %0d", tag, mis_pulses,
               ((mis && !killed) ? 1 : 0));
    end
  endtask

  // A quiet cycle after DONE: the old request must not be re-accepted.
  task automatic idle_cycle(input string tag);
    @(negedge clk);
    req_valid  = 1'b0;
    exn        = 1'b0;
    bus_ready  = 1'b0;
    bus_rvalid = 1'b0;
    #1;
    n_checks++;
    if (stall !== 1'b0 || bus_valid !== 1'b0 || rdata_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL %s idle: stall=%b bus_valid=%b rdata_valid=%b, required 0 0 0",
               tag, stall, bus_valid, rdata_valid);
    end
  endtask

  task automatic check_all_zero(input string tag);
    n_checks++;
    if (stall !== 1'b0 || rdata !== 32'h0 || rdata_valid !== 1'b0 || misalign !== 1'b0 ||
        bus_valid !== 1'b0 || bus_we !== 1'b0 || bus_addr !== 32'h0 ||
        bus_wstrb !== 4'h0 || bus_wdata !== 32'h0) begin
      n_errors++;
      $display("FAIL %s outputs: stall=%b rdata=%h rv=%b mis=%b bv=%b we=%b addr=%h strb=%b wdata=%h, required all 0",
               tag, stall, rdata, rdata_valid, misalign, bus_valid, bus_we, bus_addr,
               bus_wstrb, bus_wdata);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; exn = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_wdata = '0; req_sz = '0; req_sx = 1'b0; bus_ready = 1'b0; bus_rvalid = 1'b0;
    bus_rdata = '0;
    repeat (3) @(negedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rstn = 1'b1;
    #1;
    check_all_zero("after_release");
  endtask

  task automatic test_directed();
    run_access(1'b0, 32'h100, 32'h0, 2'd2, 1'b0, 32'hDEADBEEF, 0, 0, -1, 1'b0, "word_load");
    idle_cycle("word_load");
    run_access(1'b0, 32'h103, 32'h0, 2'd0, 1'b1, 32'h80112233, 0, 0, -1, 1'b0, "byte_ld_sx");
    idle_cycle("byte_ld_sx");
    run_access(1'b0, 32'h103, 32'h0, 2'd0, 1'b0, 32'h80112233, 0, 0, -1, 1'b0, "byte_ld_zx");
    idle_cycle("byte_ld_zx");
    run_access(1'b1, 32'h0A, 32'hABCDABCD, 2'd1, 1'b0, 32'h0, 2, 0, -1, 1'b0, "half_store");
    idle_cycle("half_store");
    run_access(1'b0, 32'h202, 32'h0, 2'd1, 1'b1, 32'h9ABC1234, 1, 2, -1, 1'b1, "half_ld_junk_rv");
    idle_cycle("half_ld_junk_rv");
    run_access(1'b0, 32'h40, 32'h0, 2'd3, 1'b1, 32'hF0E0D0C0, 0, 1, -1, 1'b0, "size3_load");
    idle_cycle("size3_load");
  endtask

  task automatic test_flush();
    // cycle 0 IDLE, 1 ADDR (ready), 2..4 RDATA: exn lands in RDATA
    run_access(1'b0, 32'h300, 32'h0, 2'd2, 1'b0, 32'h12345678, 0, 2, 3, 1'b0, "exn_rdata");
    idle_cycle("exn_rdata");
    run_access(1'b1, 32'h304, 32'h55AA55AA, 2'd2, 1'b0, 32'h0, 2, 0, 1, 1'b0, "exn_addr");
    idle_cycle("exn_addr");
    run_access(1'b0, 32'h301, 32'h0, 2'd0, 1'b1, 32'h0000FF00, 0, 0, -1, 1'b0, "after_exn");
    idle_cycle("after_exn");
  endtask

  task automatic test_back_to_back();
    run_access(1'b1, 32'h500, 32'h11111111, 2'd0, 1'b0, 32'h0, 0, 0, -1, 1'b0, "b2b_st");
    run_access(1'b0, 32'h502, 32'h0, 2'd1, 1'b0, 32'h8001_7FFF, 0, 0, -1, 1'b0, "b2b_ld");
    run_access(1'b1, 32'h506, 32'h22222222, 2'd1, 1'b0, 32'h0, 1, 0, -1, 1'b0, "b2b_st2");
    idle_cycle("b2b");
  endtask

  task automatic test_misalign();
    run_access(1'b0, 32'h102, 32'h0, 2'd2, 1'b0, 32'hCAFEF00D, 0, 0, -1, 1'b0, "mis_word");
    idle_cycle("mis_word");
    run_access(1'b1, 32'h107, 32'hA5A5A5A5, 2'd1, 1'b0, 32'h0, 0, 0, -1, 1'b0, "mis_half");
    idle_cycle("mis_half");
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h0000_0A0C; req_wdata = 32'h77777777;
    req_sz = 2'd2; req_sx = 1'b0; exn = 1'b0; bus_ready = 1'b0; bus_rvalid = 1'b0;
    @(negedge clk);
    #1;
    n_checks++;
    if (bus_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL rst_mid setup: bus_valid=%b, required 1", bus_valid);
    end
    rstn = 1'b0;
    req_valid = 1'b0;
    #1;
    check_all_zero("rst_mid");
    @(negedge clk);
    rstn = 1'b1;
    run_access(1'b0, 32'h0C, 32'h0, 2'd2, 1'b0, 32'h0BADF00D, 1, 1, -1, 1'b0, "post_rst_load");
    idle_cycle("post_rst_load");
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      logic        we, sx;
      logic [31:0] addr;
      logic [1:0]  sz;
      we   = 1'($urandom);
      sx   = 1'($urandom);
      sz   = 2'($urandom);
      addr = $urandom;
      run_access(we, addr, $urandom, sz, sx, $urandom,
                 int'($urandom_range(3, 0)), int'($urandom_range(3, 0)),
                 (($urandom_range(7, 0) == 0) ? 0 : -1), 1'($urandom), "random");
      if ($urandom_range(1, 0) == 0) idle_cycle("random");
    end
    idle_cycle("random_end");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_flush();
    test_back_to_back();
    test_misalign();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
